// File: rtl/spi_fetch_pkg.sv
// spi_fetch_pkg: shared FSM states, SPI READ command constants and flash address helper.
package spi_fetch_pkg;
  typedef enum logic [2:0] {IDLE, START, CMD, DATA, STOP, GAP} state_t;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int SPI_ADDR_W = 24;
  localparam int CMD_BITS = 32;
  function automatic logic [SPI_ADDR_W-1:0] frame_addr(input logic [SPI_ADDR_W-1:0] base, input int idx, input int stride);
    return base + SPI_ADDR_W'(idx * stride);
  endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: mode-0 SCLK toggle register with rising/falling toggle strobes.
module spi_sclk_gen (
  input  logic CLK_40,
  input  logic reset,
  input  logic spi_clk_en,
  input  logic en,
  output logic sclk,
  output logic rise_evt,
  output logic fall_evt
);
  assign rise_evt = spi_clk_en & en & ~sclk;
  assign fall_evt = spi_clk_en & en & sclk;
  always_ff @(posedge CLK_40) sclk <= reset ? 1'b0 : sclk ^ (spi_clk_en & en);
endmodule

// File: rtl/spi_frame_fetcher.sv
// spi_frame_fetcher: SPI READ (0x03) master streaming 1-bpp frames from flash as pixel writes.
module spi_frame_fetcher
  import spi_fetch_pkg::*;
#(
  parameter int FRAME_BITS = 48,
  parameter int NUM_FRAMES = 4,
  parameter logic [23:0] START_ADDR = 24'h000000,
  localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic CLK_40,
  input  logic reset,
  input  logic spi_clk_en,
  input  logic frame_req,
  input  logic MISO,
  output logic SPI_CS_n,
  output logic SPI_SCLK,
  output logic SPI_MOSI,
  output logic pixel_data,
  output logic pixel_we,
  output logic frame_done,
  output logic busy,
  output logic [IDX_W-1:0] frame_index
);
  localparam int FRAME_BYTES = (FRAME_BITS + 7) / 8;
  localparam int CNT_W = $clog2(CMD_BITS + FRAME_BITS + 1);
  state_t state, state_nx;
  logic [CMD_BITS-1:0] sr, load;
  logic [CNT_W-1:0] cnt;
  logic pending, rise, fall, req;
  assign req = frame_req | pending;
  assign load = {CMD_READ, frame_addr(START_ADDR, int'(frame_index), FRAME_BYTES)};
  spi_sclk_gen u_sclk (
    .CLK_40(CLK_40),
    .reset(reset),
    .spi_clk_en(spi_clk_en),
    .en(state == CMD || state == DATA),
    .sclk(SPI_SCLK),
    .rise_evt(rise),
    .fall_evt(fall)
  );
  always_ff @(posedge CLK_40) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? START : IDLE;
      START:   state_nx = spi_clk_en ? CMD : START;
      CMD:     state_nx = (fall && cnt == CNT_W'(CMD_BITS)) ? DATA : CMD;
      DATA:    state_nx = (fall && cnt == CNT_W'(FRAME_BITS)) ? STOP : DATA;
      STOP:    state_nx = spi_clk_en ? GAP : STOP;
      GAP:     state_nx = spi_clk_en ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  // cnt counts SCLK rising edges: command bits in CMD, pixels in DATA
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      SPI_CS_n <= 1'b1;
      SPI_MOSI <= 1'b0;
      pixel_data <= 1'b0;
      pixel_we <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      frame_index <= '0;
      pending <= 1'b0;
      sr <= '0;
      cnt <= '0;
    end else begin
      pixel_we <= 1'b0;
      frame_done <= 1'b0;
      if (frame_req && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: if (req) begin
          SPI_CS_n <= 1'b0;
          busy <= 1'b1;
          sr <= load;
          SPI_MOSI <= load[CMD_BITS-1];
          pending <= 1'b0;
          cnt <= '0;
        end
        CMD: begin
          if (rise) cnt <= cnt + 1'b1;
          if (fall && cnt == CNT_W'(CMD_BITS)) begin
            cnt <= '0;
            SPI_MOSI <= 1'b0;
          end else if (fall) begin
            sr <= sr << 1;
            SPI_MOSI <= sr[CMD_BITS-2];
          end
        end
        DATA: if (rise) begin
          cnt <= cnt + 1'b1;
          pixel_data <= MISO;
          pixel_we <= 1'b1;
        end
        STOP: if (spi_clk_en) begin
          SPI_CS_n <= 1'b1;
          frame_done <= 1'b1;
          frame_index <= (frame_index == IDX_W'(NUM_FRAMES - 1)) ? '0 : frame_index + 1'b1;
        end
        GAP: if (spi_clk_en) busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_frame_fetcher.sv
// tb_spi_frame_fetcher: scoreboard bench with a serial flash model (16-pixel frames, 2 frames at 0x100).
module tb_spi_frame_fetcher;
  logic CLK_40 = 0, reset = 1, spi_clk_en = 0, frame_req = 0, MISO = 0;
  logic SPI_CS_n, SPI_SCLK, SPI_MOSI, pixel_data, pixel_we, frame_done, busy;
  logic [0:0] frame_index;
  typedef struct {logic [31:0] cmd; logic [15:0] pix; logic idx;} exp_t;
  exp_t sb[$];
  exp_t e_pop;
  int vectors = 0, miscompares = 0;
  int nrise = 0, npix = 0, done_cnt = 0, busy_run = 0, last_gap = 0, we_in_reset = 0, k = 0;
  logic freeze = 0, prev_sclk = 0;
  logic [31:0] cmd_cap = 0;
  logic [15:0] pix_cap = 0;
  logic [7:0] fb;

  spi_frame_fetcher #(.FRAME_BITS(16), .NUM_FRAMES(2), .START_ADDR(24'h000100)) dut (
    .CLK_40(CLK_40), .reset(reset), .spi_clk_en(spi_clk_en), .frame_req(frame_req), .MISO(MISO),
    .SPI_CS_n(SPI_CS_n), .SPI_SCLK(SPI_SCLK), .SPI_MOSI(SPI_MOSI), .pixel_data(pixel_data),
    .pixel_we(pixel_we), .frame_done(frame_done), .busy(busy), .frame_index(frame_index)
  );

  always #5 CLK_40 = ~CLK_40;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'hA5;
      24'h000101: return 8'h3C;
      24'h000102: return 8'hF0;
      24'h000103: return 8'h0F;
      default:    return 8'h00;
    endcase
  endfunction

  // monitor, flash model and SCLK strobe generator share one negedge process for ordering
  always @(negedge CLK_40) begin
    if (reset && pixel_we) we_in_reset++;
    if (pixel_we) begin
      pix_cap = {pix_cap[14:0], pixel_data};
      npix++;
    end
    if (frame_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame_done: got frame_done expected none (index %0d)", frame_index);
      end else begin
        e_pop = sb.pop_front();
        chk("mosi_cmd", cmd_cap, e_pop.cmd);
        chk("pixels", 32'(pix_cap), 32'(e_pop.pix));
        chk("pixel_we_count", npix, 16);
        chk("sclk_rises", nrise, 48);
        chk("frame_index", 32'(frame_index), 32'(e_pop.idx));
      end
    end
    if (reset) busy_run = 0;
    else if (!busy) busy_run++;
    else if (busy_run > 0) begin
      last_gap = busy_run;
      busy_run = 0;
    end
    if (SPI_CS_n) begin
      nrise = 0;
      npix = 0;
      pix_cap = 0;
      cmd_cap = 0;
    end else if (SPI_SCLK && !prev_sclk) begin
      if (nrise < 32) cmd_cap = {cmd_cap[30:0], SPI_MOSI};
      nrise++;
    end
    prev_sclk = SPI_SCLK;
    if (nrise >= 32) begin
      k = nrise - 32;
      fb = flash_byte(cmd_cap[23:0] + 24'(k / 8));
      MISO = fb[3'(7 - k % 8)];
    end else MISO = 0;
    spi_clk_en = !freeze && !spi_clk_en;
  end

  task automatic req_pulse();
    @(negedge CLK_40) frame_req = 1;
    @(negedge CLK_40) frame_req = 0;
  endtask

  task automatic req_check();
    req_pulse();
    chk("cs_latency", 32'(SPI_CS_n), 0);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      @(negedge CLK_40);
      t++;
    end
    chk("frame_done_reached", 32'(done_cnt >= target), 1);
  endtask

  task automatic wait_rise(input int n);
    int t = 0;
    while (nrise < n && t < 3000) begin
      @(negedge CLK_40);
      t++;
    end
    chk("sclk_rise_reached", 32'(nrise >= n), 1);
  endtask

  initial begin
    logic [2:0] snap;
    int diffs;
    repeat (4) @(negedge CLK_40);
    chk("rst_cs_n", 32'(SPI_CS_n), 1);
    chk("rst_sclk", 32'(SPI_SCLK), 0);
    chk("rst_mosi", 32'(SPI_MOSI), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_index", 32'(frame_index), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_pixel_we_pulses", we_in_reset, 0);
    reset = 0;
    sb.push_back('{32'h03000100, 16'hA53C, 1'b1});
    req_check();
    wait_done(1);
    sb.push_back('{32'h03000102, 16'hF00F, 1'b0});
    req_check();
    wait_done(2);
    sb.push_back('{32'h03000100, 16'hA53C, 1'b1});
    req_check();
    wait_done(3);
    sb.push_back('{32'h03000102, 16'hF00F, 1'b0});
    req_check();
    wait_rise(40);
    sb.push_back('{32'h03000100, 16'hA53C, 1'b1});
    req_pulse();
    repeat (3) @(negedge CLK_40);
    req_pulse();
    wait_done(5);
    chk("pending_idle_gap", last_gap, 1);
    repeat (300) @(negedge CLK_40);
    chk("frame_done_total", done_cnt, 5);
    req_check();
    wait_rise(37);
    @(negedge CLK_40) reset = 1;
    @(negedge CLK_40) reset = 0;
    chk("abort_cs_n", 32'(SPI_CS_n), 1);
    chk("abort_sclk", 32'(SPI_SCLK), 0);
    chk("abort_pixel_we", 32'(pixel_we), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_frame_index", 32'(frame_index), 0);
    sb.push_back('{32'h03000100, 16'hA53C, 1'b1});
    req_check();
    wait_done(6);
    sb.push_back('{32'h03000102, 16'hF00F, 1'b0});
    req_check();
    wait_rise(10);
    freeze = 1;
    repeat (2) @(negedge CLK_40);
    snap = {SPI_SCLK, SPI_MOSI, SPI_CS_n};
    diffs = 0;
    repeat (20) begin
      @(negedge CLK_40);
      if ({SPI_SCLK, SPI_MOSI, SPI_CS_n} !== snap) diffs++;
    end
    chk("freeze_stable", diffs, 0);
    chk("freeze_cs_low", 32'(snap[0]), 0);
    freeze = 0;
    wait_done(7);
    repeat (50) @(negedge CLK_40);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
